// File: rtl/spatz_vlsu_mem_adapter_pkg.sv
// Shared types for the VLSU-to-TCDM memory adapter: element type, id sizing
// and the per-transaction metadata that is kept while a request is in flight.
package spatz_vlsu_mem_adapter_pkg;

    localparam int unsigned ELEN               = 32;
    localparam int unsigned NrOutstandingDflt  = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [ELEN-1:0]                           elen_t;
    typedef logic [idx_width(NrOutstandingDflt)-1:0]   id_t;

    typedef struct packed {
        id_t  id;
        logic we;
    } meta_t;

endpackage

// File: rtl/spatz_vlsu_mem_adapter_meta_fifo.sv
// Non-fall-through metadata FIFO; usage_o is the live occupancy count and
// doubles as the adapter's outstanding-transaction counter.
module spatz_vlsu_mem_adapter_meta_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic,
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  dtype            data_i,
    input  logic            pop_i,
    output dtype            data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] usage_o
);

    dtype             mem_q [DEPTH];
    logic [AddrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AddrW-1:0] incr_ptr(input logic [AddrW-1:0] p);
        return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= incr_ptr(wptr_q);
            if (do_pop)  rptr_q <= incr_ptr(rptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/spatz_vlsu_mem_adapter.sv
// Bridges the VLSU X-interface memory handshake onto a TCDM req/gnt/rvalid
// port, returning in-order load results tagged with their request id.
module spatz_vlsu_mem_adapter
    import spatz_vlsu_mem_adapter_pkg::*;
#(
    parameter int unsigned NrOutstanding = NrOutstandingDflt,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = ELEN,
    localparam int unsigned IdWidth      = idx_width(NrOutstanding),
    localparam int unsigned CntWidth     = $clog2(NrOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   x_mem_valid_i,
    output logic                   x_mem_ready_o,
    input  logic [IdWidth-1:0]     x_mem_id_i,
    input  logic [AddrWidth-1:0]   x_mem_addr_i,
    input  logic                   x_mem_we_i,
    input  logic [DataWidth/8-1:0] x_mem_strb_i,
    input  logic [DataWidth-1:0]   x_mem_wdata_i,
    output logic                   x_mem_result_valid_o,
    output logic [IdWidth-1:0]     x_mem_result_id_o,
    output logic [DataWidth-1:0]   x_mem_result_rdata_o,
    output logic                   tcdm_req_o,
    input  logic                   tcdm_gnt_i,
    output logic [AddrWidth-1:0]   tcdm_add_o,
    output logic                   tcdm_wen_o,
    output logic [DataWidth/8-1:0] tcdm_be_o,
    output logic [DataWidth-1:0]   tcdm_wdata_o,
    input  logic                   tcdm_rvalid_i,
    input  logic [DataWidth-1:0]   tcdm_rdata_i,
    output logic [CntWidth-1:0]    outstanding_o,
    output logic                   idle_o
);

    // Sized from the instance parameters so overrides of NrOutstanding stay consistent.
    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               we;
    } tx_meta_t;

    tx_meta_t meta_in, meta_head;
    logic     meta_full, meta_empty;
    logic     push, pop, load_rsp;

    // Full comes from registered occupancy only, so a same-cycle rvalid never
    // frees a slot for the current request.
    assign tcdm_req_o    = x_mem_valid_i & ~meta_full;
    assign x_mem_ready_o = tcdm_req_o & tcdm_gnt_i;
    assign tcdm_add_o    = x_mem_addr_i;
    assign tcdm_wen_o    = x_mem_we_i;
    assign tcdm_be_o     = x_mem_strb_i;
    assign tcdm_wdata_o  = x_mem_wdata_i;

    assign push     = x_mem_ready_o;
    assign pop      = tcdm_rvalid_i & ~meta_empty;
    assign load_rsp = pop & ~meta_head.we;
    assign meta_in  = '{id: x_mem_id_i, we: x_mem_we_i};

    spatz_vlsu_mem_adapter_meta_fifo #(
        .DEPTH (NrOutstanding),
        .dtype (tx_meta_t)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (meta_in),
        .pop_i   (pop),
        .data_o  (meta_head),
        .full_o  (meta_full),
        .empty_o (meta_empty),
        .usage_o (outstanding_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_mem_result_valid_o <= 1'b0;
            x_mem_result_id_o    <= '0;
            x_mem_result_rdata_o <= '0;
        end else begin
            x_mem_result_valid_o <= load_rsp;
            if (load_rsp) begin
                x_mem_result_id_o    <= meta_head.id;
                x_mem_result_rdata_o <= tcdm_rdata_i;
            end
        end
    end

    assign idle_o = (outstanding_o == '0);

    // A response with nothing in flight is dropped above; flag it here.
    rvalid_without_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) tcdm_rvalid_i |-> !meta_empty
    );

endmodule

// File: tb/tb_spatz_vlsu_mem_adapter.sv
// Randomized bench with a queue-based reference of the adapter and a
// scoreboard of expected load results checked by an independent monitor.
module tb_spatz_vlsu_mem_adapter;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          x_valid = 0, x_we = 0, gnt = 0, rvalid = 0;
    logic [IW-1:0] x_id = '0;
    logic [AW-1:0] x_addr = '0;
    logic [3:0]    x_strb = '0;
    logic [DW-1:0] x_wdata = '0, rdata = '0;

    logic          x_ready, res_valid, tcdm_req, tcdm_wen, idle;
    logic [IW-1:0] res_id;
    logic [DW-1:0] res_rdata, tcdm_wdata;
    logic [AW-1:0] tcdm_add;
    logic [3:0]    tcdm_be;
    logic [CW-1:0] outstanding;

    spatz_vlsu_mem_adapter #(.NrOutstanding(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .x_mem_valid_i(x_valid), .x_mem_ready_o(x_ready), .x_mem_id_i(x_id),
        .x_mem_addr_i(x_addr), .x_mem_we_i(x_we), .x_mem_strb_i(x_strb),
        .x_mem_wdata_i(x_wdata),
        .x_mem_result_valid_o(res_valid), .x_mem_result_id_o(res_id),
        .x_mem_result_rdata_o(res_rdata),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(gnt), .tcdm_add_o(tcdm_add),
        .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_wdata_o(tcdm_wdata),
        .tcdm_rvalid_i(rvalid), .tcdm_rdata_i(rdata),
        .outstanding_o(outstanding), .idle_o(idle)
    );

    typedef struct { logic [IW-1:0] id; logic we; } meta_m_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; int due; } exp_t;

    meta_m_t       mq[$];
    exp_t          exp_q[$];
    int            cyc = 0;
    logic [IW-1:0] last_id = '0;
    logic [DW-1:0] last_data = '0;
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a transaction list in grant order; responses pop the oldest.
    always @(posedge clk or negedge rst_n) begin
        meta_m_t m;
        bit      full, hs;
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            last_id   = '0;
            last_data = '0;
        end else begin
            cyc++;
            full = (mq.size() == N);
            hs   = x_valid && !full && gnt;
            if (rvalid && mq.size() > 0) begin
                m = mq.pop_front();
                if (!m.we) begin
                    exp_q.push_back('{m.id, rdata, cyc});
                    last_id   = m.id;
                    last_data = rdata;
                end
            end
            if (hs) mq.push_back('{x_id, x_we});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   req_e;
        req_e = x_valid && (mq.size() < N);
        chk("tcdm_req", tcdm_req, req_e);
        chk("x_mem_ready", x_ready, req_e && gnt);
        chk("outstanding", outstanding, mq.size());
        chk("idle", idle, mq.size() == 0);
        chk("passthrough", {tcdm_add, tcdm_wen, tcdm_be, tcdm_wdata},
            {x_addr, x_we, x_strb, x_wdata});
        chk("result_id_hold", res_id, last_id);
        chk("result_rdata_hold", res_rdata, last_data);
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result_timing", cyc, e.due);
                chk("result_id", res_id, e.id);
                chk("result_rdata", res_rdata, e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_result", 0, 1);
        end
    end

    task automatic drive(input bit v, input logic [IW-1:0] i, input logic [AW-1:0] a,
                         input bit w, input logic [DW-1:0] wd, input bit g,
                         input bit rv, input logic [DW-1:0] rd);
        x_valid = v; x_id = i; x_addr = a; x_we = w; x_wdata = wd;
        x_strb = wd[3:0] | 4'h1; gnt = g; rvalid = rv; rdata = rd;
        @(negedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) drive(0, '0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && mq.size() > 0; k++)
            drive(0, '0, '0, 0, '0, 0, 1, $urandom);
        chk("drain_timeout", mq.size(), 0);
        idle_cycles(2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_result_valid", res_valid, 0);
        chk("rst_result_id", res_id, 0);
        chk("rst_result_rdata", res_rdata, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_req", tcdm_req, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // single load, response two cycles after grant
        drive(1, 3'd3, 32'h100, 0, '0, 1, 0, '0);
        chk("single_outstanding", outstanding, 1);
        idle_cycles(1);
        drive(0, '0, '0, 0, '0, 0, 1, 32'hDEADBEEF);
        chk("single_pulse", res_valid, 1);
        chk("single_id", res_id, 3);
        chk("single_rdata", res_rdata, 32'hDEADBEEF);
        idle_cycles(2);

        // store then load, back-to-back responses
        drive(1, 3'd1, 32'h200, 1, 32'h1234_5678, 1, 0, '0);
        drive(1, 3'd2, 32'h204, 0, '0, 1, 0, '0);
        drive(0, '0, '0, 0, '0, 0, 1, 32'h5555_AAAA);
        chk("store_no_pulse", res_valid, 0);
        drive(0, '0, '0, 0, '0, 0, 1, 32'hCAFE_F00D);
        chk("load_pulse_id", res_id, 2);
        idle_cycles(2);
        chk("store_load_idle", idle, 1);

        // credit limit
        for (int i = 0; i < N; i++) drive(1, IW'(i), 32'h400 + 4 * i, 0, '0, 1, 0, '0);
        chk("credit_full", outstanding, N);
        drive(1, 3'd7, 32'h480, 0, '0, 1, 0, '0);
        chk("credit_blocked_req", tcdm_req, 0);
        drive(1, 3'd7, 32'h480, 0, '0, 1, 1, 32'h0BAD_F00D);
        drive(1, 3'd7, 32'h480, 0, '0, 1, 0, '0);
        chk("credit_reissue", outstanding, N);
        drain();

        // continuous grant + response keeps occupancy constant
        drive(1, 3'($urandom), 32'h500, 0, '0, 1, 0, '0);
        for (int i = 0; i < 20; i++)
            drive(1, 3'($urandom), 32'h504 + 4 * i, 0, '0, 1, 1, $urandom);
        chk("steady_outstanding", outstanding, 1);
        drain();

        // grant withheld
        for (int i = 0; i < 5; i++) drive(1, 3'd5, 32'h300, 1, 32'hA5A5_0F0F, 0, 0, '0);
        chk("nogrant_outstanding", outstanding, 0);
        drive(1, 3'd5, 32'h300, 1, 32'hA5A5_0F0F, 1, 0, '0);
        drain();

        // reset with four loads in flight and a result pulse active
        for (int i = 0; i < 5; i++) drive(1, IW'(i + 2), 32'h600 + 4 * i, 0, '0, 1, 0, '0);
        drive(0, '0, '0, 0, '0, 0, 1, 32'h1111_2222);
        chk("pre_reset_outstanding", outstanding, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_result_valid", res_valid, 0);
        chk("midrst_outstanding", outstanding, 0);
        drive(0, '0, '0, 0, '0, 0, 1, 32'h3333_4444);
        drive(0, '0, '0, 0, '0, 0, 1, 32'h5555_6666);
        rvalid = 0;
        rst_n  = 1'b1;
        idle_cycles(2);
        chk("post_reset_idle", idle, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            drive(($urandom % 4) != 0, 3'($urandom), $urandom & 32'hFFFF_FFFC, $urandom % 2,
                  $urandom, ($urandom % 3) != 0, (mq.size() > 0) && ($urandom % 2), $urandom);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
